// File: rtl/c2f_chunk_arbiter_if.sv
// C2F chunk ring types and the arbiter's producer/consumer-facing bus.
// The slave modport is the arbiter's view; the master modport is the
// producer/consumer side that drives the requests and acks.
package c2f_pkg;
    localparam int PTR_W = 4;
    localparam int OFF_W = 8;

    typedef logic [PTR_W-1:0] C2FChunkPtr;
    typedef logic [OFF_W-1:0] C2FChunkOffset;
endpackage

interface c2f_chunk_arbiter_if;
    import c2f_pkg::*;

    C2FChunkPtr              wrPtr_in;
    C2FChunkPtr              rdPtr_out;
    C2FChunkPtr    [1:0]     consWrPtr_out;
    logic          [1:0]     consEnable_in;
    logic          [1:0]     dtAck_in;
    C2FChunkOffset [1:0]     consRdOffset_in;
    C2FChunkOffset           rdOffset_out;
    logic          [1:0]     owner_out;
    logic          [1:0][31:0] chunkCount_out;
    logic                    timeoutErr_out;
    logic                    ackErr_out;

    modport slave (
        input  wrPtr_in, consEnable_in, dtAck_in, consRdOffset_in,
        output rdPtr_out, consWrPtr_out, rdOffset_out, owner_out,
               chunkCount_out, timeoutErr_out, ackErr_out
    );

    modport master (
        output wrPtr_in, consEnable_in, dtAck_in, consRdOffset_in,
        input  rdPtr_out, consWrPtr_out, rdOffset_out, owner_out,
               chunkCount_out, timeoutErr_out, ackErr_out
    );
endinterface

// File: rtl/c2f_chunk_arbiter.sv
// Round-robin arbiter handing whole C2F ring chunks to one of two consumers.
// A consumer owns one chunk until it pulses dtAck (or the optional watchdog
// expires); the non-owner sees an empty ring throughout.
module c2f_chunk_arbiter
    import c2f_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic               sysClk_in,
    input  logic               sysRstN_in,
    c2f_chunk_arbiter_if.slave bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_owner;
    logic             r_last_owner;
    C2FChunkPtr       r_rd_ptr;
    logic [31:0]      r_wd_cnt;
    logic [1:0][31:0] r_chunk_cnt;
    logic             r_timeout_err;
    logic             r_ack_err;

    logic w_own_idx;
    logic w_chunk_avail;
    logic w_grant;
    logic w_grant_idx;
    logic w_owner_ack;
    logic w_stray_ack;
    logic w_timeout;
    logic w_release;

    assign w_own_idx     = r_owner[1];
    assign w_chunk_avail = (bus.wrPtr_in != r_rd_ptr);
    assign w_release     = w_owner_ack | w_timeout;

    // Next-state, grant selection, ack classification and watchdog expiry.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_idx = 1'b0;
        w_owner_ack = 1'b0;
        w_stray_ack = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stray_ack = |bus.dtAck_in;
                if (w_chunk_avail && (|bus.consEnable_in)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_OWN;
                    case (bus.consEnable_in)
                        2'b01:   w_grant_idx = 1'b0;
                        2'b10:   w_grant_idx = 1'b1;
                        default: w_grant_idx = ~r_last_owner;
                    endcase
                end
            end
            S_OWN: begin
                w_owner_ack = bus.dtAck_in[w_own_idx];
                w_stray_ack = bus.dtAck_in[~w_own_idx];
                w_timeout   = (TIMEOUT != 0) && !w_owner_ack &&
                              (r_wd_cnt == (TIMEOUT - 32'd1));
                if (w_owner_ack || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; synchronous reset returns to S_IDLE.
    always_ff @(posedge sysClk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!sysRstN_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ownership, read pointer, watchdog, statistics and sticky error flags.
    always_ff @(posedge sysClk_in) begin
        if (!sysRstN_in) begin
            r_owner       <= 2'b00;
            r_last_owner  <= 1'b1;
            r_rd_ptr      <= '0;
            r_wd_cnt      <= '0;
            r_chunk_cnt   <= '0;
            r_timeout_err <= 1'b0;
            r_ack_err     <= 1'b0;
        end else begin
            if (w_stray_ack) begin
                r_ack_err <= 1'b1;
            end
            if (w_grant) begin
                r_owner  <= w_grant_idx ? 2'b10 : 2'b01;
                r_wd_cnt <= '0;
            end else if (r_state == S_OWN) begin
                if (w_release) begin
                    r_rd_ptr     <= r_rd_ptr + 1'b1;
                    r_last_owner <= w_own_idx;
                    r_owner      <= 2'b00;
                end else if (TIMEOUT != 0) begin
                    r_wd_cnt <= r_wd_cnt + 32'd1;
                end
                if (w_owner_ack) begin
                    r_chunk_cnt[w_own_idx] <= r_chunk_cnt[w_own_idx] + 32'd1;
                end
                if (w_timeout) begin
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

    // Per-consumer pointer views and RAM read-offset mux.
    always_comb begin
        bus.consWrPtr_out[0] = r_rd_ptr;
        bus.consWrPtr_out[1] = r_rd_ptr;
        bus.rdOffset_out     = bus.consRdOffset_in[0];
        if (r_state == S_OWN) begin
            bus.consWrPtr_out[w_own_idx] = bus.wrPtr_in;
            bus.rdOffset_out             = bus.consRdOffset_in[w_own_idx];
        end
    end

    assign bus.rdPtr_out      = r_rd_ptr;
    assign bus.owner_out      = r_owner;
    assign bus.chunkCount_out = r_chunk_cnt;
    assign bus.timeoutErr_out = r_timeout_err;
    assign bus.ackErr_out     = r_ack_err;

endmodule

// File: tb/tb_c2f_chunk_arbiter.sv
// Bench for c2f_chunk_arbiter: directed scenarios plus randomized traffic,
// all compared against a chunk-level behavioural model of the arbiter.
module tb_c2f_chunk_arbiter;
    import c2f_pkg::*;

    localparam int unsigned TB_TIMEOUT = 8;
    localparam int          PTR_MOD    = 1 << PTR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    c2f_chunk_arbiter_if u_if();
    c2f_chunk_arbiter_if u_if_nt();

    c2f_chunk_arbiter #(.TIMEOUT(TB_TIMEOUT)) u_dut (
        .sysClk_in  (clk),
        .sysRstN_in (rst_n),
        .bus        (u_if)
    );

    c2f_chunk_arbiter #(.TIMEOUT(0)) u_dut_nt (
        .sysClk_in  (clk),
        .sysRstN_in (rst_n),
        .bus        (u_if_nt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Owner is a consumer number, or -1 when the ring is not handed out.
    int          m_owner = -1;
    int          m_last  = 1;
    int          m_rd    = 0;
    int          m_held  = 0;
    logic [31:0] m_cnt [2];
    bit          m_terr  = 0;
    bit          m_aerr  = 0;

    task automatic model_step();
        logic [1:0] en;
        logic [1:0] ack;
        en  = u_if.consEnable_in;
        ack = u_if.dtAck_in;
        if (!rst_n) begin
            m_owner = -1; m_last = 1; m_rd = 0; m_held = 0;
            m_cnt[0] = 0; m_cnt[1] = 0; m_terr = 0; m_aerr = 0;
            return;
        end
        if (m_owner < 0) begin
            if (ack != 2'b00) m_aerr = 1;
            if (int'(u_if.wrPtr_in) != m_rd && en != 2'b00) begin
                if (en == 2'b11)      m_owner = 1 - m_last;
                else if (en == 2'b10) m_owner = 1;
                else                  m_owner = 0;
                m_held = 1;
            end
        end else begin
            if (ack[1 - m_owner]) m_aerr = 1;
            if (ack[m_owner]) begin
                m_cnt[m_owner] = m_cnt[m_owner] + 1;
                m_rd = (m_rd + 1) % PTR_MOD; m_last = m_owner; m_owner = -1;
            end else if (TB_TIMEOUT != 0 && m_held == int'(TB_TIMEOUT)) begin
                m_terr = 1;
                m_rd = (m_rd + 1) % PTR_MOD; m_last = m_owner; m_owner = -1;
            end else begin
                m_held++;
            end
        end
    endtask

    function automatic logic [87:0] model_vec();
        C2FChunkPtr    rd;
        C2FChunkPtr    cw0;
        C2FChunkPtr    cw1;
        C2FChunkOffset off;
        logic [1:0]    own;
        rd  = C2FChunkPtr'(m_rd);
        cw0 = (m_owner == 0) ? u_if.wrPtr_in : rd;
        cw1 = (m_owner == 1) ? u_if.wrPtr_in : rd;
        off = (m_owner == 1) ? u_if.consRdOffset_in[1] : u_if.consRdOffset_in[0];
        own = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        return {rd, cw1, cw0, off, own, m_cnt[1], m_cnt[0], m_terr, m_aerr};
    endfunction

    function automatic logic [87:0] dut_vec();
        return {u_if.rdPtr_out, u_if.consWrPtr_out, u_if.rdOffset_out,
                u_if.owner_out, u_if.chunkCount_out,
                u_if.timeoutErr_out, u_if.ackErr_out};
    endfunction

    // One clock: model sees the same pre-edge inputs the DUT samples,
    // outputs are then observed 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        u_if.dtAck_in = 2'b00;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    // Serve chunks (owner acks at once) until rdPtr reaches target.
    task automatic advance_to(input int target, input logic [1:0] en);
        u_if.consEnable_in = en;
        u_if.wrPtr_in      = C2FChunkPtr'(target);
        for (int c = 0; c < 200 && m_rd != target; c++) begin
            u_if.dtAck_in = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
            cycle();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL advance_model got=%h exp=%h", dut_vec(), model_vec());
            end
        end
        u_if.dtAck_in = 2'b00;
        n_tests++;
        if (u_if.rdPtr_out !== C2FChunkPtr'(target)) begin
            n_fail++;
            $display("FAIL advance_reach got=%0d exp=%0d", u_if.rdPtr_out, target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        n_tests++;
        if ({u_if.rdPtr_out, u_if.owner_out, u_if.chunkCount_out,
             u_if.timeoutErr_out, u_if.ackErr_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_values got rd=%0d own=%b cnt=%h terr=%b aerr=%b exp all 0",
                     u_if.rdPtr_out, u_if.owner_out, u_if.chunkCount_out,
                     u_if.timeoutErr_out, u_if.ackErr_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_own [3];
        exp_own = '{2'b01, 2'b10, 2'b01};
        apply_reset();
        u_if.consEnable_in = 2'b11;
        u_if.wrPtr_in      = 4'd3;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 4 && u_if.owner_out == 2'b00; w++) cycle();
            n_tests++;
            if (u_if.owner_out !== exp_own[k]) begin
                n_fail++;
                $display("FAIL rr_grant%0d got=%b exp=%b", k, u_if.owner_out, exp_own[k]);
            end
            repeat (5) begin
                cycle();
                n_tests++;
                if (dut_vec() !== model_vec()) begin
                    n_fail++;
                    $display("FAIL rr_hold got=%h exp=%h", dut_vec(), model_vec());
                end
            end
            u_if.dtAck_in = exp_own[k];
            cycle();
            u_if.dtAck_in = 2'b00;
            n_tests++;
            if (u_if.rdPtr_out !== C2FChunkPtr'(k + 1) || u_if.owner_out !== 2'b00) begin
                n_fail++;
                $display("FAIL rr_release%0d got rd=%0d own=%b exp rd=%0d own=00",
                         k, u_if.rdPtr_out, u_if.owner_out, k + 1);
            end
        end
        n_tests++;
        if (u_if.chunkCount_out !== {32'd1, 32'd2}) begin
            n_fail++;
            $display("FAIL rr_counts got=%h exp=%h", u_if.chunkCount_out, {32'd1, 32'd2});
        end
        repeat (5) begin
            cycle();
            n_tests++;
            if (u_if.owner_out !== 2'b00) begin
                n_fail++;
                $display("FAIL rr_idle got=%b exp=00", u_if.owner_out);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        advance_to(PTR_MOD - 1, 2'b01);
        u_if.consEnable_in = 2'b10;
        u_if.wrPtr_in      = 4'd0;
        cycle();
        n_tests++;
        if (u_if.owner_out !== 2'b10 || u_if.consWrPtr_out !== {4'd0, 4'd15}) begin
            n_fail++;
            $display("FAIL wrap_grant got own=%b cw=%h exp own=10 cw=0f",
                     u_if.owner_out, u_if.consWrPtr_out);
        end
        u_if.dtAck_in = 2'b10;
        cycle();
        u_if.dtAck_in = 2'b00;
        n_tests++;
        if (u_if.rdPtr_out !== 4'd0 || u_if.chunkCount_out[1] !== 32'd1) begin
            n_fail++;
            $display("FAIL wrap_ptr got rd=%0d cnt1=%0d exp rd=0 cnt1=1",
                     u_if.rdPtr_out, u_if.chunkCount_out[1]);
        end
    endtask

    task automatic test_timeout();
        int n_own;
        apply_reset();
        u_if.consEnable_in = 2'b01;
        u_if.wrPtr_in      = 4'd1;
        cycle();
        n_own = 0;
        for (int c = 0; c < 20 && u_if.owner_out != 2'b00; c++) begin
            n_own++;
            cycle();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL timeout_model got=%h exp=%h", dut_vec(), model_vec());
            end
        end
        n_tests++;
        if (n_own !== 8) begin
            n_fail++;
            $display("FAIL timeout_cycles got=%0d exp=8", n_own);
        end
        n_tests++;
        if (u_if.timeoutErr_out !== 1'b1 || u_if.rdPtr_out !== 4'd1 ||
            u_if.chunkCount_out[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL timeout_release got terr=%b rd=%0d cnt0=%0d exp 1 1 0",
                     u_if.timeoutErr_out, u_if.rdPtr_out, u_if.chunkCount_out[0]);
        end
    endtask

    task automatic test_dual_ack();
        apply_reset();
        u_if.consEnable_in = 2'b01;
        u_if.wrPtr_in      = 4'd1;
        cycle();
        u_if.dtAck_in = 2'b11;
        cycle();
        u_if.dtAck_in = 2'b00;
        n_tests++;
        if (u_if.rdPtr_out !== 4'd1 || u_if.ackErr_out !== 1'b1 ||
            u_if.chunkCount_out !== {32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL dual_ack got rd=%0d aerr=%b cnt=%h exp rd=1 aerr=1 cnt=%h",
                     u_if.rdPtr_out, u_if.ackErr_out, u_if.chunkCount_out, {32'd0, 32'd1});
        end
    endtask

    task automatic test_reset_mid_own();
        apply_reset();
        advance_to(5, 2'b11);
        u_if.wrPtr_in = 4'd6;
        cycle();
        n_tests++;
        if (u_if.owner_out === 2'b00) begin
            n_fail++;
            $display("FAIL midrst_own got=%b exp=nonzero", u_if.owner_out);
        end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        n_tests++;
        if ({u_if.rdPtr_out, u_if.owner_out, u_if.chunkCount_out,
             u_if.timeoutErr_out, u_if.ackErr_out} !== '0) begin
            n_fail++;
            $display("FAIL midrst_values got rd=%0d own=%b cnt=%h exp all 0",
                     u_if.rdPtr_out, u_if.owner_out, u_if.chunkCount_out);
        end
        cycle();
        n_tests++;
        if (u_if.owner_out !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_regrant got=%b exp=01", u_if.owner_out);
        end
    endtask

    task automatic test_empty_ring();
        int ptrs [2];
        ptrs = '{0, 0};
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            if (p == 1) begin
                advance_to(9, 2'b01);
                advance_to(0, 2'b10);
            end
            u_if.consEnable_in = 2'b11;
            u_if.wrPtr_in      = C2FChunkPtr'(ptrs[p]);
            for (int c = 0; c < 20; c++) begin
                cycle();
                n_tests++;
                if (u_if.owner_out !== 2'b00 ||
                    u_if.consWrPtr_out !== {C2FChunkPtr'(ptrs[p]), C2FChunkPtr'(ptrs[p])}) begin
                    n_fail++;
                    $display("FAIL empty_ring%0d got own=%b cw=%h exp own=00 ptr=%0d",
                             p, u_if.owner_out, u_if.consWrPtr_out, ptrs[p]);
                end
            end
        end
    endtask

    task automatic test_no_timeout();
        apply_reset();
        u_if_nt.consEnable_in = 2'b01;
        u_if_nt.wrPtr_in      = 4'd1;
        repeat (40) cycle();
        n_tests++;
        if (u_if_nt.owner_out !== 2'b01 || u_if_nt.timeoutErr_out !== 1'b0 ||
            u_if_nt.rdPtr_out !== 4'd0) begin
            n_fail++;
            $display("FAIL no_timeout_hold got own=%b terr=%b rd=%0d exp 01 0 0",
                     u_if_nt.owner_out, u_if_nt.timeoutErr_out, u_if_nt.rdPtr_out);
        end
        u_if_nt.dtAck_in = 2'b01;
        cycle();
        u_if_nt.dtAck_in = 2'b00;
        n_tests++;
        if (u_if_nt.rdPtr_out !== 4'd1 || u_if_nt.chunkCount_out[0] !== 32'd1) begin
            n_fail++;
            $display("FAIL no_timeout_ack got rd=%0d cnt0=%0d exp 1 1",
                     u_if_nt.rdPtr_out, u_if_nt.chunkCount_out[0]);
        end
        u_if_nt.consEnable_in = 2'b00;
    endtask

    task automatic test_random();
        int stray;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 15) u_if.wrPtr_in = C2FChunkPtr'($urandom_range(0, PTR_MOD - 1));
            if ($urandom_range(0, 9) == 0)  u_if.consEnable_in = 2'($urandom_range(0, 3));
            u_if.consRdOffset_in[0] = C2FChunkOffset'($urandom);
            u_if.consRdOffset_in[1] = C2FChunkOffset'($urandom);
            u_if.dtAck_in = 2'b00;
            if (m_owner >= 0 && $urandom_range(0, 3) == 0) u_if.dtAck_in[m_owner] = 1'b1;
            if ($urandom_range(0, 19) == 0) begin
                stray = int'($urandom_range(0, 1));
                u_if.dtAck_in[stray] = 1'b1;
            end
            rst_n = ($urandom_range(0, 199) != 0);
            cycle();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
            end
        end
        rst_n = 1'b1;
        u_if.dtAck_in = 2'b00;
    endtask

    initial begin
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        u_if.wrPtr_in           = '0;
        u_if.consEnable_in      = 2'b00;
        u_if.dtAck_in           = 2'b00;
        u_if.consRdOffset_in    = '0;
        u_if_nt.wrPtr_in        = '0;
        u_if_nt.consEnable_in   = 2'b00;
        u_if_nt.dtAck_in        = 2'b00;
        u_if_nt.consRdOffset_in = '0;

        test_reset();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_dual_ack();
        test_reset_mid_own();
        test_empty_ring();
        test_no_timeout();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit exceeded, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
